// File: rtl/axi_slave_mem_pkg.sv
// Shared types and constants for the axi_slave_mem responder.
package axi_slave_mem_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    // Write FSM states
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // Read FSM states
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Map an accumulated error flag onto the response code
    function automatic logic [1:0] resp_of(input logic err);
        return err ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle between the master driver and the axi_slave_mem responder.
interface axi_slave_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWLOCK;
    logic [3:0]            AWCACHE;
    logic [2:0]            AWPROT;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARLOCK;
    logic [3:0]            ARCACHE;
    logic [2:0]            ARPROT;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

endinterface

// File: rtl/axi_slave_mem_burst_addr.sv
// Combinational AXI burst next-address generator and burst-legality check.
module axi_slave_mem_burst_addr
    import axi_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  illegal
);
    localparam logic [2:0]            MAX_SIZE = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            wrap_log2_s;
    logic                  wrap_len_ok_s;
    logic [ADDR_WIDTH-1:0] step_s;
    logic [ADDR_WIDTH-1:0] incr_s;
    logic [ADDR_WIDTH-1:0] mask_s;

    // Wrap bursts span 2, 4, 8 or 16 beats; record log2 of the beat count
    always_comb begin
        case (len)
            8'd1:    begin wrap_log2_s = 3'd1; wrap_len_ok_s = 1'b1; end
            8'd3:    begin wrap_log2_s = 3'd2; wrap_len_ok_s = 1'b1; end
            8'd7:    begin wrap_log2_s = 3'd3; wrap_len_ok_s = 1'b1; end
            8'd15:   begin wrap_log2_s = 3'd4; wrap_len_ok_s = 1'b1; end
            default: begin wrap_log2_s = 3'd0; wrap_len_ok_s = 1'b0; end
        endcase
    end

    // Next beat address per burst type; wrap keeps the upper bits of the window
    always_comb begin
        step_s = ONE << size;
        incr_s = addr + step_s;
        mask_s = (step_s << wrap_log2_s) - ONE;
        case (burst)
            FIXED:   next_addr = addr;
            INCR:    next_addr = incr_s;
            WRAP:    next_addr = (addr & ~mask_s) | (incr_s & mask_s);
            default: next_addr = addr;
        endcase
        illegal = (size > MAX_SIZE) || (burst == 2'b11) || ((burst == WRAP) && !wrap_len_ok_s);
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 responder backed by a word-addressed memory; independent read and write FSMs.
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 1024
) (
    input logic            clk,
    input logic            rst,
    axi_slave_mem_if.slave bus
);
    localparam int                    OFFSET  = $clog2(STRB_WIDTH);
    localparam int                    MEM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    // Byte address falls beyond the last memory word
    function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] idx;
        idx = {1'b0, a >> OFFSET};
        return idx >= DEPTH_L;
    endfunction

    // Memory word index of a byte address
    function automatic logic [MEM_AW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] w;
        w = a >> OFFSET;
        return w[MEM_AW-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write path ----------------
    logic [1:0]            w_state_q,  w_state_d;
    logic [ID_WIDTH-1:0]   aw_id_q,    aw_id_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q,  aw_addr_d;
    logic [7:0]            aw_len_q,   aw_len_d;
    logic [2:0]            aw_size_q,  aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d;
    logic [7:0]            w_cnt_q,    w_cnt_d;
    logic                  w_err_q,    w_err_d;
    logic [ID_WIDTH-1:0]   bid_q,      bid_d;
    logic [1:0]            bresp_q,    bresp_d;

    logic [ADDR_WIDTH-1:0] wr_next_addr_s;
    logic                  wr_illegal_s;
    logic                  wr_last_s;
    logic                  wr_oor_s;
    logic                  wr_beat_err_s;
    logic                  wr_en_s;

    axi_slave_mem_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_wr_addr (
        .addr      (aw_addr_q),
        .size      (aw_size_q),
        .len       (aw_len_q),
        .burst     (aw_burst_q),
        .next_addr (wr_next_addr_s),
        .illegal   (wr_illegal_s)
    );

    assign wr_last_s     = (w_cnt_q == aw_len_q);
    assign wr_oor_s      = addr_oor(aw_addr_q);
    assign wr_beat_err_s = wr_illegal_s || wr_oor_s || (bus.WLAST != wr_last_s);
    assign wr_en_s       = (w_state_q == W_DATA) && bus.WVALID && !wr_illegal_s && !wr_oor_s;

    // Write FSM: latch AW, count beats (beat count ends the burst), then hold B
    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (bus.AWVALID) begin
                    aw_id_d    = bus.AWID;
                    aw_addr_d  = bus.AWADDR;
                    aw_len_d   = bus.AWLEN;
                    aw_size_d  = bus.AWSIZE;
                    aw_burst_d = bus.AWBURST;
                    w_cnt_d    = 8'd0;
                    w_err_d    = 1'b0;
                    w_state_d  = W_DATA;
                end else begin
                    w_state_d  = W_IDLE;
                end
            end
            W_DATA: begin
                if (bus.WVALID) begin
                    aw_addr_d = wr_next_addr_s;
                    w_cnt_d   = w_cnt_q + 8'd1;
                    w_err_d   = w_err_q || wr_beat_err_s;
                    if (wr_last_s) begin
                        bid_d     = aw_id_q;
                        bresp_d   = resp_of(w_err_q || wr_beat_err_s);
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bus.BREADY) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Write path state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= {ID_WIDTH{1'b0}};
            aw_addr_q  <= {ADDR_WIDTH{1'b0}};
            aw_len_q   <= 8'd0;
            aw_size_q  <= 3'd0;
            aw_burst_q <= 2'd0;
            w_cnt_q    <= 8'd0;
            w_err_q    <= 1'b0;
            bid_q      <= {ID_WIDTH{1'b0}};
            bresp_q    <= 2'd0;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Byte-lane memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (bus.WSTRB[b]) begin
                    mem[addr_idx(aw_addr_q)][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read path ----------------
    logic [0:0]            r_state_q,  r_state_d;
    logic [ID_WIDTH-1:0]   ar_id_q,    ar_id_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q,  ar_addr_d;
    logic [7:0]            ar_len_q,   ar_len_d;
    logic [2:0]            ar_size_q,  ar_size_d;
    logic [1:0]            ar_burst_q, ar_burst_d;
    logic [7:0]            r_cnt_q,    r_cnt_d;
    logic [ID_WIDTH-1:0]   rid_q,      rid_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic [1:0]            rresp_q,    rresp_d;
    logic                  rlast_q,    rlast_d;
    logic                  rvalid_q,   rvalid_d;

    logic                  rd_idle_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic [2:0]            rd_size_s;
    logic [7:0]            rd_len_s;
    logic [1:0]            rd_burst_s;
    logic [ADDR_WIDTH-1:0] rd_next_addr_s;
    logic                  rd_illegal_s;
    logic [ADDR_WIDTH-1:0] rd_fetch_addr_s;
    logic                  rd_err_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // In idle the calculator sees the incoming AR so the first beat can be checked
    assign rd_idle_s  = (r_state_q == R_IDLE);
    assign rd_addr_s  = rd_idle_s ? bus.ARADDR  : ar_addr_q;
    assign rd_size_s  = rd_idle_s ? bus.ARSIZE  : ar_size_q;
    assign rd_len_s   = rd_idle_s ? bus.ARLEN   : ar_len_q;
    assign rd_burst_s = rd_idle_s ? bus.ARBURST : ar_burst_q;

    axi_slave_mem_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_rd_addr (
        .addr      (rd_addr_s),
        .size      (rd_size_s),
        .len       (rd_len_s),
        .burst     (rd_burst_s),
        .next_addr (rd_next_addr_s),
        .illegal   (rd_illegal_s)
    );

    // Fetch the beat about to be presented; reading before the write edge gives old data
    always_comb begin
        rd_fetch_addr_s = rd_idle_s ? bus.ARADDR : rd_next_addr_s;
        rd_err_s        = rd_illegal_s || addr_oor(rd_fetch_addr_s);
        if (rd_err_s) begin
            rd_word_s = {DATA_WIDTH{1'b0}};
        end else begin
            rd_word_s = mem[addr_idx(rd_fetch_addr_s)];
        end
    end

    // Read FSM: accept AR, stream beats back-to-back, payload held under backpressure
    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        rvalid_d   = rvalid_q;
        case (r_state_q)
            R_IDLE: begin
                if (bus.ARVALID) begin
                    ar_id_d    = bus.ARID;
                    ar_addr_d  = bus.ARADDR;
                    ar_len_d   = bus.ARLEN;
                    ar_size_d  = bus.ARSIZE;
                    ar_burst_d = bus.ARBURST;
                    r_cnt_d    = 8'd0;
                    rid_d      = bus.ARID;
                    rdata_d    = rd_word_s;
                    rresp_d    = resp_of(rd_err_s);
                    rlast_d    = (bus.ARLEN == 8'd0);
                    rvalid_d   = 1'b1;
                    r_state_d  = R_DATA;
                end else begin
                    r_state_d  = R_IDLE;
                end
            end
            R_DATA: begin
                if (bus.RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        ar_addr_d = rd_next_addr_s;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        rdata_d   = rd_word_s;
                        rresp_d   = resp_of(rd_err_s);
                        rlast_d   = ((r_cnt_q + 8'd1) == ar_len_q);
                        r_state_d = R_DATA;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Read path state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q  <= R_IDLE;
            ar_id_q    <= {ID_WIDTH{1'b0}};
            ar_addr_q  <= {ADDR_WIDTH{1'b0}};
            ar_len_q   <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
            r_cnt_q    <= 8'd0;
            rid_q      <= {ID_WIDTH{1'b0}};
            rdata_q    <= {DATA_WIDTH{1'b0}};
            rresp_q    <= 2'd0;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Lock/cache/prot carry no meaning for this memory
    logic unused_s;
    assign unused_s = ^{bus.AWLOCK, bus.AWCACHE, bus.AWPROT, bus.ARLOCK, bus.ARCACHE, bus.ARPROT};

    assign bus.AWREADY = (w_state_q == W_IDLE);
    assign bus.WREADY  = (w_state_q == W_DATA);
    assign bus.BVALID  = (w_state_q == W_RESP);
    assign bus.BID     = bid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = (r_state_q == R_IDLE);
    assign bus.RVALID  = rvalid_q;
    assign bus.RID     = rid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RLAST   = rlast_q;

endmodule
